// File: rtl/reg_group_ctrl_pkg.sv
// Shared definitions for the register-group micro-sequencer: opcodes, FSM
// state encoding and instruction field positions.
package reg_group_ctrl_pkg;

    // Opcode encodings in instr[7:6]
    localparam logic [1:0] OP_LDI = 2'b00;
    localparam logic [1:0] OP_MOV = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    // Instruction field bit positions
    localparam int unsigned OP_MSB   = 7;
    localparam int unsigned OP_LSB   = 6;
    localparam int unsigned RSVD_MSB = 5;
    localparam int unsigned RSVD_LSB = 4;
    localparam int unsigned DR_MSB   = 3;
    localparam int unsigned DR_LSB   = 2;
    localparam int unsigned SR_MSB   = 1;
    localparam int unsigned SR_LSB   = 0;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StExec  = 2'd2,
        StWrite = 2'd3
    } state_e;

    function automatic logic [1:0] get_op(input logic [7:0] ins);
        return ins[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [1:0] get_rsvd(input logic [7:0] ins);
        return ins[RSVD_MSB:RSVD_LSB];
    endfunction

    function automatic logic [1:0] get_dr(input logic [7:0] ins);
        return ins[DR_MSB:DR_LSB];
    endfunction

    function automatic logic [1:0] get_sr(input logic [7:0] ins);
        return ins[SR_MSB:SR_LSB];
    endfunction

endpackage

// File: rtl/reg_group_ctrl_alu.sv
// Combinational register ALU: a is the destination operand, b the source.
// ADD carry is the sum's top bit; SUB carry is the borrow (a < b).
module reg_alu
    import reg_group_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    // Top bit of the extended difference is set exactly when a < b
    assign diff = {1'b0, a} - {1'b0, b};

    // Select result and flag by opcode; LDI/MOV pass the source through
    always_comb begin
        result = b;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
            end
            OP_SUB: begin
                result = diff[WIDTH-1:0];
                carry  = diff[WIDTH];
            end
            OP_LDI, OP_MOV: begin
                result = b;
                carry  = 1'b0;
            end
            default: begin
                result = b;
                carry  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/reg_group_ctrl.sv
// Micro-sequencer executing one register instruction at a time against the
// 4xWIDTH register group. Owns the only write path into the group.
module reg_group_ctrl
    import reg_group_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    input  logic [7:0]       instr,
    input  logic [WIDTH-1:0] imm,
    output logic             instr_ready,
    output logic             done,
    output logic             carry,
    output logic [1:0]       rg_sr,
    output logic [1:0]       rg_dr,
    output logic             rg_we,
    output logic [WIDTH-1:0] rg_i,
    input  logic [WIDTH-1:0] rg_s,
    input  logic [WIDTH-1:0] rg_d
);

    state_e           state_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_res_q;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic [1:0]       instr_op;
    logic             unused_rsvd;

    assign instr_op    = get_op(instr);
    // Reserved instruction bits carry no meaning
    assign unused_rsvd = ^get_rsvd(instr);

    // Ready only in IDLE and never while reset is held
    assign instr_ready = rst_n && (state_q == StIdle);

    reg_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op     (op_q),
        .a      (rg_d),
        .b      (rg_s),
        .result (alu_result),
        .carry  (alu_carry)
    );

    // Sequencer FSM with capture registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            op_q        <= OP_LDI;
            result_q    <= '0;
            carry_res_q <= 1'b0;
            carry       <= 1'b0;
            done        <= 1'b0;
            rg_sr       <= 2'd0;
            rg_dr       <= 2'd0;
            rg_we       <= 1'b0;
            rg_i        <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (instr_valid) begin
                        op_q  <= instr_op;
                        rg_sr <= get_sr(instr);
                        rg_dr <= get_dr(instr);
                        if (instr_op == OP_LDI) begin
                            // LDI needs no operands: go straight to the write
                            result_q <= imm;
                            rg_i     <= imm;
                            rg_we    <= 1'b1;
                            state_q  <= StWrite;
                        end else begin
                            state_q <= StRead;
                        end
                    end
                end
                StRead: begin
                    // Selects have been stable for a cycle; sample the operands
                    result_q    <= alu_result;
                    carry_res_q <= alu_carry;
                    state_q     <= StExec;
                end
                StExec: begin
                    if (op_q == OP_ADD || op_q == OP_SUB) begin
                        carry <= carry_res_q;
                    end
                    rg_i    <= result_q;
                    rg_we   <= 1'b1;
                    state_q <= StWrite;
                end
                StWrite: begin
                    // Group commits on the falling edge inside this cycle
                    rg_we   <= 1'b0;
                    done    <= 1'b1;
                    state_q <= StIdle;
                end
                default: begin
                    rg_we   <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_group_ctrl.sv
// Directed bench for reg_group_ctrl with a behavioural 4x8 register group.
module tb_reg_group_ctrl;

    logic       clk;
    logic       rst_n;
    logic       instr_valid;
    logic [7:0] instr;
    logic [7:0] imm;
    logic       instr_ready;
    logic       done;
    logic       carry;
    logic [1:0] rg_sr;
    logic [1:0] rg_dr;
    logic       rg_we;
    logic [7:0] rg_i;
    logic [7:0] rg_s;
    logic [7:0] rg_d;

    int checks = 0;
    int errors = 0;

    // Register group model: no reset, commits on the falling edge
    logic [7:0] regs [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int         we_count = 0;
    int         we_in_reset = 0;
    logic [9:0] wlog [$];

    assign rg_s = regs[rg_sr];
    assign rg_d = regs[rg_dr];

    always @(negedge clk) begin
        if (rg_we) begin
            regs[rg_dr] <= rg_i;
            we_count++;
            wlog.push_back({rg_dr, rg_i});
            if (!rst_n) we_in_reset++;
        end
    end

    reg_group_ctrl #(
        .WIDTH (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .imm         (imm),
        .instr_ready (instr_ready),
        .done        (done),
        .carry       (carry),
        .rg_sr       (rg_sr),
        .rg_dr       (rg_dr),
        .rg_we       (rg_we),
        .rg_i        (rg_i),
        .rg_s        (rg_s),
        .rg_d        (rg_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one instruction from IDLE and wait for done. exp_lat counts cycles
    // after the accept edge: cycle 1 is the one right after it.
    // Returns in the done cycle (IDLE again).
    task automatic run_instr(input logic [7:0] ins, input logic [7:0] im,
                             input int exp_lat, input string name);
        int c;
        int we0;
        int ready_bad;
        bit seen;
        we0 = we_count;
        ready_bad = 0;
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before_issue got %b want 1", name, instr_ready);
        end
        instr_valid = 1'b1;
        instr = ins;
        imm = im;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr = 8'h00;
        imm = 8'h00;
        c = 1;
        seen = 0;
        while (c <= 12 && !seen) begin
            if (done === 1'b1) begin
                seen = 1;
            end else begin
                if (instr_ready !== 1'b0) ready_bad++;
                @(posedge clk); #1;
                c++;
            end
        end
        checks++;
        if (!seen || c != exp_lat) begin
            errors++;
            $display("FAIL %s done_latency got %0d (seen=%0d) want %0d", name, c, seen, exp_lat);
        end
        checks++;
        if (ready_bad != 0) begin
            errors++;
            $display("FAIL %s ready_while_busy got %0d cycles want 0", name, ready_bad);
        end
        checks++;
        if (we_count - we0 != 1) begin
            errors++;
            $display("FAIL %s we_cycles got %0d want 1", name, we_count - we0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        instr_valid = 1'b0;
        instr = 8'h00;
        imm = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rg_we !== 1'b0 || done !== 1'b0 || carry !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got we=%b done=%b carry=%b want 0 0 0", rg_we, done, carry);
        end
        checks++;
        if (rg_sr !== 2'd0 || rg_dr !== 2'd0 || rg_i !== 8'h00) begin
            errors++;
            $display("FAIL reset_selects got sr=%0d dr=%0d i=%h want 0 0 00", rg_sr, rg_dr, rg_i);
        end
        checks++;
        if (instr_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_low got %b want 0", instr_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_after got %b want 1", instr_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ldi();
        run_instr(8'h08, 8'h5A, 2, "ldi_r2");
        checks++;
        if (wlog.size() == 0 || wlog[wlog.size()-1] !== {2'd2, 8'h5A}) begin
            errors++;
            $display("FAIL ldi_write got %h want %h", wlog.size() == 0 ? 10'h0 : wlog[wlog.size()-1], {2'd2, 8'h5A});
        end
        @(posedge clk); #1;
        checks++;
        if (regs[2] !== 8'h5A) begin
            errors++;
            $display("FAIL ldi_r2_value got %h want 5a", regs[2]);
        end
        checks++;
        if (done !== 1'b0 || rg_we !== 1'b0) begin
            errors++;
            $display("FAIL ldi_pulse_end got done=%b we=%b want 0 0", done, rg_we);
        end
    endtask

    task automatic test_mov();
        run_instr(8'h42, 8'h00, 4, "mov_r0_r2");
        checks++;
        if (rg_sr !== 2'd2 || rg_dr !== 2'd0) begin
            errors++;
            $display("FAIL mov_selects got sr=%0d dr=%0d want 2 0", rg_sr, rg_dr);
        end
        checks++;
        if (regs[0] !== 8'h5A || carry !== 1'b0) begin
            errors++;
            $display("FAIL mov_result got r0=%h carry=%b want 5a 0", regs[0], carry);
        end
    endtask

    task automatic test_add();
        run_instr(8'h04, 8'hF0, 2, "ldi_r1");
        run_instr(8'h0C, 8'h20, 2, "ldi_r3");
        run_instr(8'h87, 8'h00, 4, "add_r1_r3");
        checks++;
        if (regs[1] !== 8'h10 || carry !== 1'b1) begin
            errors++;
            $display("FAIL add_wrap got r1=%h carry=%b want 10 1", regs[1], carry);
        end
        run_instr(8'h85, 8'h00, 4, "add_r1_r1");
        checks++;
        if (regs[1] !== 8'h20 || carry !== 1'b0) begin
            errors++;
            $display("FAIL add_double got r1=%h carry=%b want 20 0", regs[1], carry);
        end
    endtask

    task automatic test_sub();
        run_instr(8'h00, 8'h10, 2, "ldi_r0");
        run_instr(8'hC3, 8'h00, 4, "sub_r0_r3");
        checks++;
        if (regs[0] !== 8'hF0 || carry !== 1'b1) begin
            errors++;
            $display("FAIL sub_borrow got r0=%h carry=%b want f0 1", regs[0], carry);
        end
        // MOV R1<-R0 must leave the borrow flag alone
        run_instr(8'h44, 8'h00, 4, "mov_r1_r0");
        checks++;
        if (regs[1] !== 8'hF0 || carry !== 1'b1) begin
            errors++;
            $display("FAIL mov_keeps_carry got r1=%h carry=%b want f0 1", regs[1], carry);
        end
        run_instr(8'hCF, 8'h00, 4, "sub_r3_r3");
        checks++;
        if (regs[3] !== 8'h00 || carry !== 1'b0) begin
            errors++;
            $display("FAIL sub_self got r3=%h carry=%b want 00 0", regs[3], carry);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ins_l [3];
        logic [7:0] imm_l [3];
        logic [9:0] exp_l [3];
        int idx;
        int cyc;
        int base;
        ins_l = '{8'h00, 8'h04, 8'h81};
        imm_l = '{8'h01, 8'h02, 8'h00};
        exp_l = '{{2'd0, 8'h01}, {2'd1, 8'h02}, {2'd0, 8'h03}};
        base = wlog.size();
        idx = 0;
        cyc = 0;
        instr_valid = 1'b1;
        instr = ins_l[0];
        imm = imm_l[0];
        // Valid stays high; present the next instruction only after an accept
        while (idx < 3 && cyc < 40) begin
            if (instr_ready === 1'b1) begin
                @(posedge clk); #1;
                idx++;
                if (idx < 3) begin
                    instr = ins_l[idx];
                    imm = imm_l[idx];
                end
            end else begin
                @(posedge clk); #1;
            end
            cyc++;
        end
        instr_valid = 1'b0;
        instr = 8'h00;
        imm = 8'h00;
        checks++;
        if (idx != 3) begin
            errors++;
            $display("FAIL b2b_accepts got %0d want 3", idx);
        end
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (wlog.size() - base != 3) begin
            errors++;
            $display("FAIL b2b_write_count got %0d want 3", wlog.size() - base);
        end
        for (int i = 0; i < 3; i++) begin
            if (base + i < wlog.size()) begin
                checks++;
                if (wlog[base+i] !== exp_l[i]) begin
                    errors++;
                    $display("FAIL b2b_write%0d got %h want %h", i, wlog[base+i], exp_l[i]);
                end
            end
        end
        checks++;
        if (regs[0] !== 8'h03 || carry !== 1'b0) begin
            errors++;
            $display("FAIL b2b_result got r0=%h carry=%b want 03 0", regs[0], carry);
        end
    endtask

    task automatic test_reset_mid();
        int we0;
        // Set carry first so the reset clearing it is visible
        run_instr(8'h0C, 8'hFF, 2, "ldi_r3_ff");
        run_instr(8'h8D, 8'h00, 4, "add_r3_r1");
        checks++;
        if (regs[3] !== 8'h01 || carry !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_add got r3=%h carry=%b want 01 1", regs[3], carry);
        end
        we0 = we_count;
        instr_valid = 1'b1;
        instr = 8'h87;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr = 8'h00;
        @(posedge clk); #1;
        // Now in EXEC
        rst_n = 1'b0;
        #2;
        checks++;
        if (rg_we !== 1'b0 || carry !== 1'b0 || instr_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs got we=%b carry=%b ready=%b done=%b want 0 0 0 0",
                     rg_we, carry, instr_ready, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (we_count != we0 || regs[1] !== 8'h02) begin
            errors++;
            $display("FAIL mid_reset_no_write got writes=%0d r1=%h want 0 02", we_count - we0, regs[1]);
        end
        checks++;
        if (we_in_reset != 0 || carry !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_state got we_in_reset=%0d carry=%b want 0 0", we_in_reset, carry);
        end
        run_instr(8'h04, 8'h77, 2, "ldi_after_reset");
        @(posedge clk); #1;
        checks++;
        if (regs[1] !== 8'h77) begin
            errors++;
            $display("FAIL ldi_after_reset_value got %h want 77", regs[1]);
        end
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_mov();
        test_add();
        test_sub();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
